// File: rtl/ctrl_fsm_if.sv
// ctrl_fsm_if: handshake and datapath-control bundle between the multi-cycle
// control unit (master) and the datapath/memory side (slave).
interface ctrl_fsm_if #(
  parameter int OPW = 4,
  parameter int FSW = 4
);
  logic [OPW-1:0] opcode;
  logic           Z;
  logic           mem_ready;
  logic           mem_req;
  logic [1:0]     PS;
  logic           IL;
  logic           MB;
  logic           MD;
  logic           RW;
  logic           MM;
  logic           MW;
  logic [FSW-1:0] FS;
  logic [2:0]     state_o;
  logic           halted;
  logic           fault;

  modport master (
    input  opcode, Z, mem_ready,
    output mem_req, PS, IL, MB, MD, RW, MM, MW, FS, state_o, halted, fault
  );

  modport slave (
    output opcode, Z, mem_ready,
    input  mem_req, PS, IL, MB, MD, RW, MM, MW, FS, state_o, halted, fault
  );
endinterface

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: registered FETCH -> EXEC -> MEM control unit with a memory
// request/ready handshake, a wait-cycle timeout that traps into FAULT, and an
// optional HALT instruction enabled by defining the macro HALT_EN.
module ctrl_fsm #(
  parameter int OPW         = 4,
  parameter int FSW         = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  ctrl_fsm_if.master    bus
);

  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Remembers whether the pending MEM access is a store (1) or a load (0).
  logic             st_q, st_d;

  logic           mem_req_c;
  logic [1:0]     ps_c;
  logic           il_c, mb_c, md_c, rw_c, mm_c, mw_c;
  logic [FSW-1:0] fs_c;
  logic           halted_c, fault_c;

  logic           cls;
  logic [2:0]     sub;

  assign cls = bus.opcode[OPW-1];
  assign sub = bus.opcode[2:0];

  // State, wait counter and access-type registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
    end
  end

  // Next-state, wait counter and control outputs; everything is forced to 0
  // while reset is held so no partial PS/RW/MW pulse escapes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    st_d      = st_q;
    mem_req_c = 1'b0;
    ps_c      = 2'b00;
    il_c      = 1'b0;
    mb_c      = 1'b0;
    md_c      = 1'b0;
    rw_c      = 1'b0;
    mm_c      = 1'b0;
    mw_c      = 1'b0;
    fs_c      = '0;
    halted_c  = 1'b0;
    fault_c   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        mm_c      = 1'b1;
        if (bus.mem_ready) begin
          il_c    = 1'b1;
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        if (!cls) begin
          fs_c = bus.opcode[FSW-1:0];
          rw_c = 1'b1;
          ps_c = 2'b01;
        end else begin
          case (sub)
            3'b000: begin
              fs_c = bus.opcode[FSW-1:0];
              rw_c = 1'b1;
              mb_c = 1'b1;
              ps_c = 2'b01;
            end
            3'b001: begin
              st_d    = 1'b0;
              state_d = S_MEM;
            end
            3'b010: begin
              st_d    = 1'b1;
              state_d = S_MEM;
            end
            3'b011: ps_c = bus.Z ? 2'b10 : 2'b01;
            3'b100: ps_c = bus.Z ? 2'b01 : 2'b10;
            3'b101: begin
`ifdef HALT_EN
              ps_c    = 2'b00;
              state_d = S_HALT;
`else
              ps_c    = 2'b01;
`endif
            end
            3'b110: ps_c = 2'b10;
            default: ps_c = 2'b11;
          endcase
        end
      end

      S_MEM: begin
        mem_req_c = 1'b1;
        mw_c      = st_q;
        if (bus.mem_ready) begin
          ps_c    = 2'b01;
          md_c    = ~st_q;
          rw_c    = ~st_q;
          state_d = S_FETCH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HALT: begin
        halted_c = 1'b1;
      end

      S_FAULT: begin
        halted_c = 1'b1;
        fault_c  = 1'b1;
      end

      default: begin
        state_d = S_FAULT;
      end
    endcase

    // Every state change starts the wait budget afresh.
    if (state_d != state_q) begin
      cnt_d = '0;
    end

    if (!rst_n) begin
      mem_req_c = 1'b0;
      ps_c      = 2'b00;
      il_c      = 1'b0;
      mb_c      = 1'b0;
      md_c      = 1'b0;
      rw_c      = 1'b0;
      mm_c      = 1'b0;
      mw_c      = 1'b0;
      fs_c      = '0;
      halted_c  = 1'b0;
      fault_c   = 1'b0;
    end
  end

  assign bus.mem_req = mem_req_c;
  assign bus.PS      = ps_c;
  assign bus.IL      = il_c;
  assign bus.MB      = mb_c;
  assign bus.MD      = md_c;
  assign bus.RW      = rw_c;
  assign bus.MM      = mm_c;
  assign bus.MW      = mw_c;
  assign bus.FS      = fs_c;
  assign bus.state_o = rst_n ? state_q : 3'd0;
  assign bus.halted  = halted_c;
  assign bus.fault   = fault_c;

endmodule
